// File: rtl/emu_state_bridge.sv
// Host-link bridge for a board emulator: takes 4-byte input-state frames, drives SW/KEY,
// waits for the board model to settle, then returns the sampled LED/HEX outputs as a 9-byte frame.
module emu_state_bridge #(
   parameter int SETTLE_CYCLES = 4,
   parameter int TIMEOUT       = 1000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [9:0]  sw_out,
   output logic [3:0]  key_out,
   input  logic [51:0] outputs_in,
   output logic        busy,
   output logic [7:0]  err_count
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
   localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, RX_B0, RX_B1, RX_CHK, SETTLE, TX_HDR, TX_DATA, TX_CHK
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      b0_q, b0_d;
   logic [7:0]      b1_q, b1_d;
   logic [9:0]      sw_q, sw_d;
   logic [3:0]      key_q, key_d;
   logic [51:0]     cap_q, cap_d;
   logic [7:0]      settle_q, settle_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      err_q, err_d;

   logic            err_inc;
   logic            to_expired;
   logic [55:0]     cap_ext;
   logic [7:0]      resp_chk;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         b0_q     <= '0;
         b1_q     <= '0;
         sw_q     <= '0;
         key_q    <= '0;
         cap_q    <= '0;
         settle_q <= '0;
         to_q     <= '0;
         idx_q    <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         b0_q     <= b0_d;
         b1_q     <= b1_d;
         sw_q     <= sw_d;
         key_q    <= key_d;
         cap_q    <= cap_d;
         settle_q <= settle_d;
         to_q     <= to_d;
         idx_q    <= idx_d;
         err_q    <= err_d;
      end
   end

   assign to_expired = (to_q == TO_LAST);

   // Request parsing, settle timing and response sequencing; bytes seen outside IDLE/RX are dropped.
   always_comb begin
      state_d  = state_q;
      b0_d     = b0_q;
      b1_d     = b1_q;
      sw_d     = sw_q;
      key_d    = key_q;
      cap_d    = cap_q;
      settle_d = settle_q;
      to_d     = to_q;
      idx_d    = idx_q;
      err_d    = err_q;
      err_inc  = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_valid && (rx_data == 8'hA5)) begin
               to_d    = '0;
               state_d = RX_B0;
            end
         end
         RX_B0: begin
            if (rx_valid) begin
               b0_d    = rx_data;
               to_d    = '0;
               state_d = RX_B1;
            end else if (to_expired) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         RX_B1: begin
            if (rx_valid) begin
               b1_d    = rx_data;
               to_d    = '0;
               state_d = RX_CHK;
            end else if (to_expired) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         RX_CHK: begin
            if (rx_valid) begin
               if ((rx_data == (b0_q ^ b1_q)) && (b1_q[7:6] == 2'b00)) begin
                  sw_d     = {b1_q[1:0], b0_q};
                  key_d    = b1_q[5:2];
                  settle_d = '0;
                  state_d  = SETTLE;
               end else begin
                  err_inc = 1'b1;
                  state_d = IDLE;
               end
            end else if (to_expired) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               cap_d   = outputs_in;
               state_d = TX_HDR;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         TX_HDR: begin
            if (tx_ready) begin
               idx_d   = '0;
               state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_ready) begin
               if (idx_q == 3'd6) begin
                  state_d = TX_CHK;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         TX_CHK: begin
            if (tx_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (err_inc && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   assign cap_ext = {4'b0000, cap_q};

   always_comb begin
      resp_chk = '0;
      for (int i = 0; i < 7; i++) begin
         resp_chk = resp_chk ^ cap_ext[i*8 +: 8];
      end
   end

   // tx_data is a pure function of state, so it cannot change while the sink stalls.
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      case (state_q)
         TX_HDR: begin
            tx_valid = 1'b1;
            tx_data  = 8'h5A;
         end
         TX_DATA: begin
            tx_valid = 1'b1;
            tx_data  = cap_ext[{idx_q, 3'b000} +: 8];
         end
         TX_CHK: begin
            tx_valid = 1'b1;
            tx_data  = resp_chk;
         end
         default: begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
         end
      endcase
   end

   assign sw_out    = sw_q;
   assign key_out   = key_q;
   assign busy      = (state_q != IDLE);
   assign err_count = err_q;

endmodule

// File: doc/emu_state_bridge.md
EMU_STATE_BRIDGE -- requirements
Module: emu_state_bridge

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, range 1..255: cycles between applying new inputs and sampling outputs.
REQ-002 SHALL have parameter TIMEOUT, default 1000: idle cycles allowed between bytes of a request frame.
REQ-003 SHALL have port CLK input 1: sole clock, rising edge.
REQ-004 SHALL have port RST input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port rx_data input 8: request byte from host link.
REQ-006 SHALL have port rx_valid input 1: rx_data valid for exactly this cycle; no backpressure.
REQ-007 SHALL have port tx_data output 8: response byte to host link.
REQ-008 SHALL have port tx_valid output 1: tx_data valid.
REQ-009 SHALL have port tx_ready input 1: sink accepts tx_data when high with tx_valid.
REQ-010 SHALL have port sw_out output 10: drives board-model SW[9:0] (inputs_state[9:0]).
REQ-011 SHALL have port key_out output 4: drives board-model KEY[3:0] (inputs_state[13:10]).
REQ-012 SHALL have port outputs_in input 52: {HEX5,HEX4,HEX3,HEX2,HEX1,HEX0,LED}; LED in [9:0], HEX0 in [16:10], HEX5 in [51:45].
REQ-013 SHALL have port busy output 1: high in any state other than IDLE.
REQ-014 SHALL have port err_count output 8: count of rejected request frames, saturating at 255.

Function
REQ-015 Request frame SHALL be 4 bytes: 0xA5, B0 = inputs_state[7:0], B1 = {2'b00, inputs_state[13:8]}, CHK = B0 ^ B1.
REQ-016 Response frame SHALL be 9 bytes: 0x5A, D0..D6 = outputs_in sampled, little-endian, D6[7:4] = 0, then CHK = D0^D1^...^D6.
REQ-017 FSM states SHALL be IDLE, RX_B0, RX_B1, RX_CHK, SETTLE, TX_HDR, TX_DATA, TX_CHK.
REQ-018 In IDLE, an rx_valid byte other than 0xA5 SHALL be ignored without error; 0xA5 SHALL move to RX_B0.
REQ-019 RX_B0 -> RX_B1 -> RX_CHK SHALL each advance on one rx_valid byte.
REQ-020 In RX_CHK, a received CHK mismatch, or B1[7:6] != 0, SHALL reject the frame: err_count +1, return to IDLE, sw_out/key_out unchanged, no response.
REQ-021 On a valid CHK, sw_out/key_out SHALL update on the clock edge that accepts CHK, and the FSM SHALL enter SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles; outputs_in SHALL be captured on the last SETTLE cycle into a 52-bit register.
REQ-023 tx_valid SHALL assert with 0x5A on the cycle after capture.
REQ-024 tx_data SHALL be held stable while tx_valid=1 and tx_ready=0; a byte transfers on any cycle with tx_valid & tx_ready; the next byte is presented on the following cycle.
REQ-025 tx_valid SHALL be continuously high from TX_HDR through TX_CHK, and SHALL drop the cycle after CHK transfers, with return to IDLE.
REQ-026 In RX_B0/RX_B1/RX_CHK, TIMEOUT consecutive cycles without rx_valid SHALL abort to IDLE with err_count +1.
REQ-027 rx_valid bytes arriving in SETTLE or TX states SHALL be dropped without error; a 0xA5 arriving there SHALL NOT start a frame.
REQ-028 err_count SHALL hold at 255 on further errors.

Reset
REQ-029 RST high SHALL immediately force IDLE, sw_out=0, key_out=0, tx_valid=0, tx_data=0, busy=0, err_count=0, and clear the capture register and the settle and timeout counters.
REQ-030 Reset asserted mid-frame or mid-response SHALL abandon the frame; after release, the first transferred byte SHALL be a 0x5A of a new response only.

Verification
REQ-031 Bytes A5 03 24 27, tx_ready=1, outputs_in=52'h155 -> sw_out=0x003, key_out=0x9 on the CHK edge; after 4 cycles, response 5A 55 01 00 00 00 00 00 54.
REQ-032 Bytes A5 03 24 00 -> err_count=1, sw_out/key_out unchanged, tx_valid never asserted, busy low after the CHK byte.
REQ-033 Bytes A5 00 C0 C0 -> rejected on reserved bits, err_count +1, no response.
REQ-034 Bytes A5 03, then 1000 idle cycles -> IDLE, err_count +1; next frame A5 FF 3F C0 -> sw_out=0x3FF, key_out=0xF, response sent.
REQ-035 tx_ready held low for 10 cycles while D2 is presented -> tx_data=D2 and tx_valid=1 stable across all 10 cycles; full 9-byte frame intact.
REQ-036 RST pulse during D3 -> outputs immediately at reset values; 300 reset assertions with err_count at 255 and extra bad frames -> err_count stays 255.
